// File: rtl/clock_div_pkg.sv
// Shared types, limits and helpers for the runtime-programmable clock divider.
package clock_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int unsigned MIN_DIV = 2;

  // Number of clk cycles per period during which the posedge phase flop is high.
  function automatic logic [31:0] half_len(input logic [31:0] n);
    return (n + 32'd1) >> 1;
  endfunction

  // Programmable high time, kept inside 1..n-1 so the output always toggles.
  function automatic logic [31:0] clamp_high(input logic [31:0] duty, input logic [31:0] n);
    if (duty < 32'd1) begin
      return 32'd1;
    end else if (duty > n - 32'd1) begin
      return n - 32'd1;
    end
    return duty;
  endfunction

endpackage

// File: rtl/clock_div_neg_stage.sv
// Negedge half of the divider: q follows p half a clk later so odd divisors get
// a half-cycle-resolution high time. Kept apart so its negedge timing can be constrained alone.
module clock_div_neg_stage (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic p_i,
  input  logic odd_i,
  output logic clk_out_o
);

  logic q_q;

  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q <= 1'b0;
    end else begin
      q_q <= p_i;
    end
  end

  // Only flop outputs feed this gate; odd_i is the registered active divisor LSB.
  assign clk_out_o = odd_i ? (p_i & q_q) : p_i;

endmodule

// File: rtl/clock_div_n.sv
// Runtime-programmable integer clock divider (N = 2..2^DIV_W-1), 50% duty, tick strobe.
// Build option CLK_DIV_DUTY_EN: adds duty_val for a programmable high time; clk_out = p.
//
//   state | meaning
//   IDLE  | parked: cnt=0, p=0, clk_out low, waiting for en
//   RUN   | counting 0..N-1; wrap reloads N from pending or parks when en=0
module clock_div_n
  import clock_div_pkg::*;
#(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
`ifdef CLK_DIV_DUTY_EN
  input  logic [DIV_W-1:0] duty_val,
`endif
  output logic             clk_out,
  output logic             tick,
  output logic             div_err,
  output logic [DIV_W-1:0] active_div
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] MIN_VAL = DIV_W'(MIN_DIV);

  state_e           state_q;
  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] active_div_q;
  logic [DIV_W-1:0] pending_q;
  logic [DIV_W-1:0] pending_d;
  logic             div_err_q;
  logic             div_err_d;
  logic             p_q;
  logic             tick_q;

  logic [DIV_W-1:0] high_len;
  logic [DIV_W-1:0] last_cnt;
  logic [DIV_W-1:0] cnt_inc;
  logic             load_ok;

  assign load_ok  = div_load && (div_val >= MIN_VAL);
  assign last_cnt = active_div_q - DIV_W'(1);
  assign cnt_inc  = cnt_q + DIV_W'(1);

  always_comb begin
    pending_d = pending_q;
    div_err_d = div_err_q;
    if (load_ok) begin
      pending_d = div_val;
    end else if (div_load) begin
      div_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= RST_DIV;
      div_err_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      div_err_q <= div_err_d;
    end
  end

`ifdef CLK_DIV_DUTY_EN
  logic [DIV_W-1:0] pending_duty_q;
  logic [DIV_W-1:0] active_duty_q;

  // Duty is captured only with an accepted divisor so the pair stays consistent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_duty_q <= DIV_W'(half_len(32'(RST_DIV)));
      active_duty_q  <= DIV_W'(half_len(32'(RST_DIV)));
    end else begin
      if (load_ok) begin
        pending_duty_q <= duty_val;
      end
      if ((state_q == IDLE && en) || (state_q == RUN && cnt_q == last_cnt && en)) begin
        active_duty_q <= pending_duty_q;
      end
    end
  end

  assign high_len = DIV_W'(clamp_high(32'(active_duty_q), 32'(active_div_q)));
`else
  assign high_len = DIV_W'(half_len(32'(active_div_q)));
`endif

  // p is registered from the next count, so it is high exactly while cnt < high_len.
  // Every period starts at cnt 0 and high_len >= 1, so the first cycle is always high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      p_q          <= 1'b0;
      tick_q       <= 1'b0;
      active_div_q <= RST_DIV;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          p_q   <= 1'b0;
          if (en) begin
            state_q      <= RUN;
            active_div_q <= pending_q;
            p_q          <= 1'b1;
            tick_q       <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == last_cnt) begin
            cnt_q <= '0;
            if (en) begin
              active_div_q <= pending_q;
              p_q          <= 1'b1;
              tick_q       <= 1'b1;
            end else begin
              state_q <= IDLE;
              p_q     <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_inc;
            p_q   <= (cnt_inc < high_len);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          p_q     <= 1'b0;
        end
      endcase
    end
  end

`ifdef CLK_DIV_DUTY_EN
  assign clk_out = p_q;
`else
  clock_div_neg_stage u_neg_stage (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .p_i       (p_q),
    .odd_i     (active_div_q[0]),
    .clk_out_o (clk_out)
  );
`endif

  assign tick       = tick_q;
  assign div_err    = div_err_q;
  assign active_div = active_div_q;

  a_div_min : assert property (@(posedge clk) disable iff (!rst_n)
    active_div_q >= MIN_VAL);
  a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == RUN) |-> (cnt_q < active_div_q));
  a_idle_quiet : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IDLE) |-> (cnt_q == '0 && !p_q));

endmodule

// File: tb/tb_clock_div_n.sv
// Self-checking bench for clock_div_n: directed scenarios plus random loads/enables,
// compared against a period-level model of the divided waveform in half-cycle units.
module tb_clock_div_n;

  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic             div_err;
  logic [DIV_W-1:0] active_div;
`ifdef CLK_DIV_DUTY_EN
  logic [DIV_W-1:0] duty_val = '0;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: running flag, position in period, divisor in use, pending, sticky error.
  bit m_run;
  int m_pos;
  int m_n;
  int m_pend;
  bit m_err;

  logic       obs_hi1, obs_hi2, obs_tick;
  logic [11:0] obs_vec;
  logic [11:0] exp_vec;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  clock_div_n #(.DIV_W(DIV_W), .DEFAULT_DIV(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .div_val    (div_val),
    .div_load   (div_load),
`ifdef CLK_DIV_DUTY_EN
    .duty_val   (duty_val),
`endif
    .clk_out    (clk_out),
    .tick       (tick),
    .div_err    (div_err),
    .active_div (active_div)
  );

  // Half-cycle k of the current period (k=0 is the first half after the period's posedge).
  // Even N is high for k in [0,N); odd N is shifted by one half: k in [1,N].
  function automatic bit model_high(int k);
    int start;
    if (!m_run) return 1'b0;
    start = m_n % 2;
    return (k >= start) && (k < start + m_n);
  endfunction

  function automatic void model_reset();
    m_run  = 1'b0;
    m_pos  = 0;
    m_n    = 3;
    m_pend = 3;
    m_err  = 1'b0;
  endfunction

  // One clk cycle: update model at the posedge, sample both halves; div_load is one-shot.
  task automatic advance();
    bit eh1, eh2, et;
    @(posedge clk);
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_pos = 0;
        m_n   = m_pend;
      end
    end else if (m_pos == m_n - 1) begin
      m_pos = 0;
      if (en) m_n = m_pend;
      else    m_run = 1'b0;
    end else begin
      m_pos++;
    end
    if (div_load) begin
      if (int'(div_val) >= 2) m_pend = int'(div_val);
      else                    m_err  = 1'b1;
    end
    #2;
    obs_hi1  = clk_out;
    obs_tick = tick;
    eh1 = model_high(2 * m_pos);
    et  = m_run && (m_pos == 0);
    obs_vec[11] = clk_out;
    obs_vec[9]  = tick;
    obs_vec[8]  = div_err;
    obs_vec[7:0] = active_div;
    @(negedge clk);
    #2;
    obs_hi2 = clk_out;
    obs_vec[10] = clk_out;
    eh2 = model_high(2 * m_pos + 1);
    exp_vec = {eh1, eh2, et, m_err, 8'(m_n)};
    div_load = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] got;
    rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    got = {clk_out, tick, div_err, active_div};
    checks++;
    if (got !== {3'b000, 8'd3}) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", got, {3'b000, 8'd3});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      advance();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL idle_quiet t=%0t got=%h exp=%h", $time, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_div3();
    int ticks = 0;
    en = 1'b1;
    repeat (12) begin
      advance();
      ticks += int'(obs_tick);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL div3 t=%0t got=%h exp=%h", $time, obs_vec, exp_vec);
      end
    end
    checks++;
    if (ticks != 4) begin
      failures++;
      $display("FAIL div3_tick_count got=%0d exp=4", ticks);
    end
  endtask

  task automatic test_reload_mid();
    int n = 0;
    while (m_pos != 1 && n < 10) begin advance(); n++; end
    if (n >= 10) begin
      checks++; failures++;
      $display("FAIL reload_wait timeout got=%0d exp=1", m_pos);
    end
    div_val = 8'd4; div_load = 1'b1;
    repeat (14) begin
      advance();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL reload_div4 t=%0t got=%h exp=%h", $time, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_div7_div2();
    int n = 0;
    int hi;
    div_val = 8'd7; div_load = 1'b1;
    do begin advance(); n++; end while (!(m_n == 7 && m_pos == 0) && n < 20);
    checks++;
    if (n >= 20) begin
      failures++;
      $display("FAIL div7_wait timeout got=%0d exp=7", m_n);
    end
    hi = int'(obs_hi1) + int'(obs_hi2);
    repeat (6) begin
      advance();
      hi += int'(obs_hi1) + int'(obs_hi2);
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL div7 t=%0t got=%h exp=%h", $time, obs_vec, exp_vec);
      end
    end
    checks++;
    if (hi != 7) begin
      failures++;
      $display("FAIL div7_high_halves got=%0d exp=7", hi);
    end
    div_val = 8'd2; div_load = 1'b1;
    repeat (12) begin
      advance();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL div2 t=%0t got=%h exp=%h", $time, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_bad_load();
    div_val = 8'd1; div_load = 1'b1;
    advance();
    checks++;
    if (div_err !== 1'b1 || active_div !== 8'd2) begin
      failures++;
      $display("FAIL bad_load_1 got err=%b div=%0d exp err=1 div=2", div_err, active_div);
    end
    div_val = 8'd0; div_load = 1'b1;
    repeat (8) begin
      advance();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL bad_load_run t=%0t got=%h exp=%h", $time, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_park();
    int n = 0;
    div_val = 8'd5; div_load = 1'b1;
    do begin advance(); n++; end while (!(m_n == 5 && m_pos == 1) && n < 20);
    if (n >= 20) begin
      checks++; failures++;
      $display("FAIL park_wait timeout got=%0d exp=5", m_n);
    end
    en = 1'b0;
    repeat (10) begin
      advance();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL park_drain t=%0t got=%h exp=%h", $time, obs_vec, exp_vec);
      end
    end
    checks++;
    if (obs_hi1 !== 1'b0 || obs_hi2 !== 1'b0 || m_run) begin
      failures++;
      $display("FAIL park_low got=%b%b exp=00", obs_hi1, obs_hi2);
    end
    en = 1'b1;
    advance();
    checks++;
    if (obs_tick !== 1'b1 || obs_hi2 !== 1'b1) begin
      failures++;
      $display("FAIL restart_first got tick=%b clk_out=%b exp tick=1 clk_out=1", obs_tick, obs_hi2);
    end
    repeat (9) begin
      advance();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL restart_run t=%0t got=%h exp=%h", $time, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    logic [10:0] got;
    div_val = 8'd6; div_load = 1'b1;
    do begin advance(); n++; end while (!(m_n == 6 && m_pos == 1) && n < 20);
    checks++;
    if (n >= 20 || obs_hi2 !== 1'b1) begin
      failures++;
      $display("FAIL arst_pre got clk_out=%b n=%0d exp clk_out=1", obs_hi2, m_n);
    end
    rst_n = 1'b0;
    #1;
    got = {clk_out, tick, div_err, active_div};
    checks++;
    if (got !== {3'b000, 8'd3}) begin
      failures++;
      $display("FAIL arst_immediate got=%h exp=%h", got, {3'b000, 8'd3});
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (9) begin
      advance();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL arst_restart t=%0t got=%h exp=%h", $time, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    repeat (400) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) begin
        div_val  = 8'($urandom_range(0, 12));
        div_load = 1'b1;
      end
      advance();
      checks++;
      if (obs_vec !== exp_vec) begin
        failures++;
        $display("FAIL random t=%0t got=%h exp=%h", $time, obs_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div3();
    test_reload_mid();
    test_div7_div2();
    test_bad_load();
    test_park();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
